// File: rtl/parport_tx.sv
// parport_tx -- Centronics-style parallel-port transmitter.
//
// Words pushed over a valid/ready interface are buffered in a small FIFO and
// sent one at a time on dout/strobe using a 4-phase strobe/ack handshake:
// dout is set up, strobe rises, the device raises ack, strobe falls, the device
// drops ack. Each ack edge is guarded by a timeout. A timeout drops the current
// word, sets a sticky error flag and parks the sender until clr_err.
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   in_data      word to transmit
//   in_valid     in_data valid
//   in_ready     FIFO can accept a word (push = in_valid & in_ready)
//   dout         [DW-1:0] data, [DW] parity bit
//   strobe       high while data is offered to the device
//   ack          device acknowledge, asynchronous to clk
//   busy         FIFO non-empty or a transfer/error in progress
//   fill         FIFO occupancy
//   timeout_err  sticky ack-timeout flag
//   clr_err      clears timeout_err and releases the error state
module parport_tx #(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int PARITY      = 1,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DW-1:0]                in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DW:0]                  dout,
  output logic                         strobe,
  input  logic                         ack,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fill,
  output logic                         timeout_err,
  input  logic                         clr_err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int FW      = $clog2(DEPTH + 1);
  // One counter serves both the setup delay and the ack timeouts.
  localparam int CNT_MAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STB,
    S_WAITLO,
    S_ERR
  } state_t;

  function automatic logic parity_of(input logic [DW-1:0] d);
    if (PARITY == 1) return ~^d;
    else if (PARITY == 2) return ^d;
    else return 1'b0;
  endfunction

  // ---------------------------------------------------------------- ack sync
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   ack_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) sync_reg[i] <= sync_reg[i-1];
      sync_reg[0] <= ack;
    end
  end

  assign ack_s = sync_reg[SYNC_STAGES-1];

  // -------------------------------------------------------------------- FIFO
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FW-1:0] fill_reg;
  logic          push, pop;

  // in_ready looks only at the current occupancy, not at a same-cycle pop.
  assign in_ready = (fill_reg != FW'(DEPTH));
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap by
  // natural overflow. Reset empties the FIFO without touching the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   fill_reg <= fill_reg + FW'(1);
        2'b01:   fill_reg <= fill_reg - FW'(1);
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  // --------------------------------------------------------------------- FSM
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [DW:0]   dout_reg, dout_next;
  logic          strobe_reg, strobe_next;
  logic          err_reg, err_next;
  logic [DW-1:0] head;

  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      dout_reg   <= '0;
      strobe_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dout_reg   <= dout_next;
      strobe_reg <= strobe_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    dout_next   = dout_reg;
    strobe_next = 1'b0;
    err_next    = err_reg;
    pop         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (fill_reg != '0) begin
          pop        = 1'b1;
          dout_next  = {parity_of(head), head};
          cnt_next   = CW'(SETUP_CYC - 1);
          state_next = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_reg == '0) begin
          strobe_next = 1'b1;
          cnt_next    = '0;
          state_next  = S_STB;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end

      S_STB: begin
        strobe_next = 1'b1;
        if (ack_s) begin
          strobe_next = 1'b0;
          cnt_next    = '0;
          state_next  = S_WAITLO;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          // Strobe has now been high for exactly TIMEOUT cycles.
          strobe_next = 1'b0;
          err_next    = 1'b1;
          state_next  = S_ERR;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      S_WAITLO: begin
        if (!ack_s) begin
          state_next = S_IDLE;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = S_ERR;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      S_ERR: begin
        // The word in flight is abandoned; nothing is re-sent on exit.
        if (clr_err) begin
          err_next   = 1'b0;
          state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign dout        = dout_reg;
  assign strobe      = strobe_reg;
  assign timeout_err = err_reg;
  assign fill        = fill_reg;
  assign busy        = (fill_reg != '0) || (state_reg != S_IDLE);

endmodule
